// File: rtl/serial_add_pkg.sv
// Shared constants and state encoding for the bit-serial adder front/back end.
package serial_add_pkg;
    localparam int WIDTH = 8;
    localparam int CW    = 4;
    localparam int RES_W = WIDTH + 1;

    typedef logic [1:0] state_t;
    localparam state_t LOAD  = 2'd0;
    localparam state_t EXEC  = 2'd1;
    localparam state_t SHIFT = 2'd2;
endpackage

// File: rtl/serial_add_sequencer_shift_reg_r.sv
// Right-shifting register: serial-in at the MSB, parallel load, sync clear.
module shift_reg_r #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         sin,
    input  logic         ld,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (ld)
            q <= din;
        else if (en)
            q <= {sin, q[W-1:1]};
    end
endmodule

// File: rtl/serial_add_sequencer.sv
// Deserializes two LSB-first operands for the external adder, then streams the
// 9-bit {cout, sum} result back out LSB-first.
module serial_add_sequencer #(
    parameter int WIDTH = serial_add_pkg::WIDTH,
    parameter int CW    = serial_add_pkg::CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);
    import serial_add_pkg::*;

    localparam int            RW       = WIDTH + 1;
    localparam logic [CW-1:0] LAST_IN  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(WIDTH);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   res;
    logic            in_fire;
    logic            out_fire;
    logic            unused_res_hi;

    assign in_ready  = (state == LOAD);
    assign busy      = ~in_ready;
    assign out_valid = (state == SHIFT);
    assign out_last  = out_valid & (cnt == LAST_OUT);
    // Gate with out_valid so the idle output is a clean 0.
    assign out_bit   = out_valid & res[0];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign unused_res_hi = ^res[RW-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
        end else begin
            case (state)
                LOAD: if (in_fire) begin
                    if (cnt == LAST_IN) begin
                        cnt   <= '0;
                        state <= EXEC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EXEC: state <= SHIFT;
                SHIFT: if (out_fire) begin
                    if (cnt == LAST_OUT) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= LOAD;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Operand registers drive the adder directly, so they only move on accepted beats.
    shift_reg_r #(.W(WIDTH)) u_a_sr (
        .clk (clk),
        .clr (rst),
        .en  (in_fire),
        .sin (in_a),
        .ld  (1'b0),
        .din ('0),
        .q   (add_a)
    );

    shift_reg_r #(.W(WIDTH)) u_b_sr (
        .clk (clk),
        .clr (rst),
        .en  (in_fire),
        .sin (in_b),
        .ld  (1'b0),
        .din ('0),
        .q   (add_b)
    );

    shift_reg_r #(.W(RW)) u_res (
        .clk (clk),
        .clr (rst),
        .en  (out_fire),
        .sin (1'b0),
        .ld  (state == EXEC),
        .din ({add_cout, add_sum}),
        .q   (res)
    );
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a queue-based result model.
module tb_serial_add_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_a = 1'b0;
    logic       in_b = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_bit, out_last, busy;
    logic [7:0] add_a, add_b, add_sum;
    logic       add_cout;

    // The external adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    serial_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: operands as shifted words, result as a queue of pending bits.
    logic [7:0] ma = '0;
    logic [7:0] mb = '0;
    logic [8:0] msum;
    int         nb = 0;
    bit         pend = 1'b0;
    bit         mq[$];
    bit         chk_en = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            ma = '0; mb = '0; nb = 0; pend = 1'b0; mq.delete();
        end else if (!pend && mq.size() == 0) begin
            if (in_valid) begin
                ma = {in_a, ma[7:1]};
                mb = {in_b, mb[7:1]};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    pend = 1'b1;
                end
            end
        end else if (pend) begin
            msum = {1'b0, ma} + {1'b0, mb};
            for (int i = 0; i < 9; i++) mq.push_back(msum[i]);
            pend = 1'b0;
        end else if (out_ready) begin
            void'(mq.pop_front());
        end
        chk_en = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("in_ready",  in_ready,  !(pend || mq.size() != 0));
            chk("busy",      busy,      pend || mq.size() != 0);
            chk("out_valid", out_valid, mq.size() != 0);
            chk("out_bit",   out_bit,   mq.size() != 0 ? mq[0] : 1'b0);
            chk("out_last",  out_last,  mq.size() == 1);
            chk("add_a",     add_a,     ma);
            chk("add_b",     add_b,     mb);
        end
    end

    // Collect emitted bits into words for literal result checks.
    logic [8:0] cw = '0;
    logic [8:0] last_res = '0;
    int         cidx = 0;
    int         nres = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            cidx = 0; cw = '0;
        end else if (out_valid && out_ready) begin
            if (cidx < 9) cw[cidx] = out_bit;
            if (out_last) begin
                last_res = cw;
                nres++;
                cidx = 0;
                cw = '0;
            end else begin
                cidx++;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input int nbeats, input bit gaps);
        int t;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            t = 0;
            while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
            if (t >= 200) chk("in_ready_timeout", in_ready, 1);
            in_valid = 1'b1;
            in_a = a[i];
            in_b = b[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int s1, input int s2, input bit noise);
        int t;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            t = 0;
            while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) chk("out_valid_timeout", out_valid, 1);
            if (k == 0) chk("first_bit_latency", t, 1);
            if (noise && k < 8) begin
                in_valid = 1'b1;
                in_a = 1'($urandom_range(0, 1));
                in_b = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            if (k == s1 || k == s2) begin
                out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("in_ready_after_last", in_ready, 1);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input bit gaps,
                      input int s1, input int s2, input bit noise, input logic [8:0] exp9);
        send(a, b, 8, gaps);
        chk("loaded_add_a", add_a, a);
        chk("loaded_add_b", add_b, b);
        chk("exec_out_valid", out_valid, 0);
        drain(s1, s2, noise);
        chk("result_word", last_res, exp9);
    endtask

    initial begin
        int n0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_add_a",     add_a,     0);

        // basic, carry-out cases
        op(8'h35, 8'h4A, 1'b0, -1, -1, 1'b0, 9'h07F);
        op(8'hFF, 8'h01, 1'b0, -1, -1, 1'b0, 9'h100);
        op(8'h80, 8'h80, 1'b0, -1, -1, 1'b0, 9'h100);
        // gaps, stalls on beat 4 and the carry beat, inputs toggling during SHIFT
        op(8'h6C, 8'hB7, 1'b1, 4, 8, 1'b1, 9'h123);
        // back-to-back
        op(8'h0F, 8'h01, 1'b0, -1, -1, 1'b0, 9'h010);
        op(8'hAA, 8'h55, 1'b0, -1, -1, 1'b0, 9'h0FF);

        // reset after 5 loaded beats
        send(8'hC3, 8'h5A, 5, 1'b0);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk("rst_load_add_a", add_a, 0);
        chk("rst_load_busy", busy, 0);
        op(8'h12, 8'h34, 1'b0, -1, -1, 1'b0, 9'h046);

        // reset after 4 result bits
        send(8'hFF, 8'h01, 8, 1'b0);
        n0 = nres;
        out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk("rst_shift_out_valid", out_valid, 0);
        chk("rst_shift_busy", busy, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_shift_no_result", nres, n0);
        op(8'h01, 8'h01, 1'b0, -1, -1, 1'b0, 9'h002);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Bit-serial front/back end for the 8-bit parallel prefix adder in the bit-serial datapath. It deserializes two operands arriving LSB-first, one bit pair per beat, and presents them as registered 8-bit words to the adder. It then captures the adder's sum and carry-out and re-serializes the 9-bit result LSB-first to the downstream serial stage. Both directions use valid/ready handshakes; there is one clock domain.

## Interface
- WIDTH, 8, operand width; only 8 is supported, matching the adder.
- CW, 4, beat counter width; must satisfy 2^CW > WIDTH.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  serial operand bit pair valid.
- in_ready  out  1  block accepts a bit pair.
- in_a  in  1  operand A bit, LSB first.
- in_b  in  1  operand B bit, LSB first.
- add_a  out  WIDTH  registered operand A to the adder.
- add_b  out  WIDTH  registered operand B to the adder.
- add_sum  in  WIDTH  adder sum, combinational from add_a/add_b.
- add_cout  in  1  adder carry-out.
- out_valid  out  1  serial result bit valid.
- out_ready  in  1  downstream accepts the result bit.
- out_bit  out  1  result bit: sum[0..7], then cout.
- out_last  out  1  high with the 9th (carry) bit.
- busy  out  1  high in EXEC or SHIFT.

## Operation
- The FSM has three states: LOAD, EXEC and SHIFT.
- **LOAD**
  - in_ready=1.
  - On each in_valid&in_ready, right-shift in_a into the MSB of a_sr and in_b into the MSB of b_sr, then increment cnt.
  - On the beat where cnt==WIDTH-1: cnt←0 and go to EXEC. After 8 beats, a_sr[i] holds the i-th bit received.
  - Gaps in in_valid hold all state.
- add_a=a_sr and add_b=b_sr at all times, so they change only on accepted beats.
- **EXEC** (exactly one cycle)
  - in_ready=0.
  - res←{add_cout, add_sum} (9 bits); go to SHIFT.
- **SHIFT**
  - out_valid=1, out_bit=res[0], out_last=(cnt==WIDTH).
  - On out_valid&out_ready: res right-shifts (zero fill) and cnt increments.
  - On the accepted beat with out_last=1: cnt←0 and go to LOAD.
  - While out_ready=0, out_bit, out_last and cnt hold.
- No overlap: in_ready=0 throughout EXEC and SHIFT; a new operand is not accepted until the carry bit is consumed.
- Arithmetic is unsigned modulo 2^8, with cout as bit 8. No carry-in.
- **Reset** (from any state, including mid-LOAD or mid-SHIFT): state←LOAD, cnt←0, a_sr, b_sr and res←0. A partially loaded operand or partially shifted result is discarded; nothing is emitted.
- Output values during and immediately after reset: in_ready=1, out_valid=0, out_bit=0, out_last=0, add_a=add_b=0, busy=0.
- Simultaneous in_valid and out_ready are legal. Only the handshake valid for the current state has effect.

## Timing
- The last operand beat is accepted at edge T. EXEC occupies cycle T..T+1, and res is captured at edge T+1.
- out_valid=1 from edge T+1. The first result bit is available one cycle after the last operand beat.
- With no stalls:
  - LOAD takes 8 cycles, EXEC 1 and SHIFT 9: 18 cycles per add.
  - in_ready rises the cycle after the carry bit is accepted.
- The adder path add_a/add_b→add_sum must close in one clk period. All block outputs are registered or decoded directly from registered state; there is no combinational in→out path.
- out_valid must not drop without a handshake. Once asserted it stays high until the out_last beat is accepted.

## Structure
- Package serial_add_pkg holds:
  - WIDTH=8 and CW=4 constants;
  - the state typedef {LOAD, EXEC, SHIFT}, 2-bit encoding;
  - RES_W=WIDTH+1.
- Sub-module shift_reg_r (parameter W, right shift, serial-in at MSB, enable, sync clear) is instantiated for a_sr, b_sr (W=8) and res (W=9; parallel-load port used in EXEC).
- The adder itself is outside this block and is connected at the next level up.

## Test plan
- **Basic add:** shift A=0x35, B=0x4A with in_valid held high → add_a=0x35, add_b=0x4A after 8 beats. out_bit sequence is 1,1,1,1,1,1,1,0, then carry 0 with out_last; out_valid is first high 1 cycle after the last beat.
- **Carry-out:** A=0xFF, B=0x01 → 8 zero bits then carry 1 with out_last. Then A=0x80, B=0x80 → sum 0x00, carry 1.
- **Backpressure and gaps:** insert random in_valid gaps and hold out_ready low 3 cycles on beat 4 and on the carry beat → out_bit and out_last stable while stalled, result unchanged, in_ready stays 0 until the carry is accepted.
- **Back-to-back:** run 0x0F+0x01=0x010, then 0xAA+0x55=0x0FF → correct 9-bit streams; in_ready=1 the cycle after each out_last handshake.
- **Reset mid-operation:**
  - rst during LOAD after 5 beats → full 8-beat load required afterwards.
  - rst during SHIFT after 4 bits → out_valid=0 next cycle, no further bits emitted, busy=0, then 0x01+0x01 yields 0x002.
